// File: rtl/rs_station_pkg.sv
// Shared definitions for the ALU reservation station.
// Holds the sizing constants, the ALU opcode encodings, the per-entry
// payload layout, and the CDB operand-snoop helper. The helper is used
// both for wakeup of stored entries and for bypass on the issue path.
package rs_station_pkg;
  localparam int RS_SIZE = 16;
  localparam int RS_BIT  = 4;
  localparam int ROB_BIT = 4;
  localparam int OP_W    = 6;
  localparam int DATA_W  = 32;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_XOR  = 6'd4,
    OP_SLL  = 6'd5,
    OP_SRL  = 6'd6,
    OP_SRA  = 6'd7,
    OP_SLT  = 6'd8,
    OP_SLTU = 6'd9
  } alu_op_e;

  // Entry payload. The busy bit lives in its own vector so that the
  // pickers can see it directly.
  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [DATA_W-1:0]  vj;
    logic [DATA_W-1:0]  vk;
    logic               qj_valid;
    logic [ROB_BIT-1:0] qj;
    logic               qk_valid;
    logic [ROB_BIT-1:0] qk;
    logic [ROB_BIT-1:0] rob_id;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  pc;
  } rs_entry_t;

  typedef struct packed {
    logic               valid;
    logic [ROB_BIT-1:0] rob_id;
    logic [DATA_W-1:0]  value;
  } cdb_t;

  typedef struct packed {
    logic              pend;
    logic [DATA_W-1:0] val;
  } operand_t;

  // Resolve one operand against both CDBs. When both buses carry the
  // same tag, cdb0 takes priority.
  function automatic operand_t snoop(input logic pend, input logic [ROB_BIT-1:0] tag,
                                     input logic [DATA_W-1:0] val,
                                     input cdb_t c0, input cdb_t c1);
    operand_t o;
    o.pend = pend;
    o.val  = val;
    if (pend && c0.valid && c0.rob_id == tag) begin
      o.pend = 1'b0;
      o.val  = c0.value;
    end else if (pend && c1.valid && c1.rob_id == tag) begin
      o.pend = 1'b0;
      o.val  = c1.value;
    end
    return o;
  endfunction
endpackage

// File: rtl/rs_picker.sv
// Lowest-index priority encoder.
// Ports: req   - request vector (bit 0 is highest priority)
//        found - some bit of req is set
//        idx   - index of the lowest set bit (0 when none)
module rs_picker #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    found = |req;
    idx   = '0;
    // Scan downward so that the lowest set bit is the last to write idx.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end
endmodule

// File: rtl/rs_station.sv
// Reservation station for the ALU path.
// The station accepts one issued instruction per cycle into the lowest
// free slot. It snoops two CDBs to resolve pending operand tags, and
// dispatches the lowest-index operand-complete entry per cycle to the
// ALU through registered outputs.
// Ports: clk_in/rst_in (sync, active-low), rdy_in (low = freeze),
//        clear_in (flush), issue_* (new entry), full_out (no free slot),
//        cdb0_*/cdb1_* (result broadcasts), alu_* (dispatched op).
module rs_station
  import rs_station_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear_in,
  input  logic               issue_valid,
  input  logic [OP_W-1:0]    issue_op,
  input  logic [DATA_W-1:0]  issue_vj,
  input  logic [DATA_W-1:0]  issue_vk,
  input  logic               issue_qj_valid,
  input  logic               issue_qk_valid,
  input  logic [ROB_BIT-1:0] issue_qj,
  input  logic [ROB_BIT-1:0] issue_qk,
  input  logic [ROB_BIT-1:0] issue_rob_id,
  input  logic [DATA_W-1:0]  issue_imm,
  input  logic [DATA_W-1:0]  issue_pc,
  output logic               full_out,
  input  logic               cdb0_valid,
  input  logic [ROB_BIT-1:0] cdb0_rob_id,
  input  logic [DATA_W-1:0]  cdb0_value,
  input  logic               cdb1_valid,
  input  logic [ROB_BIT-1:0] cdb1_rob_id,
  input  logic [DATA_W-1:0]  cdb1_value,
  output logic               alu_valid,
  output logic [OP_W-1:0]    alu_op,
  output logic [DATA_W-1:0]  alu_v1,
  output logic [DATA_W-1:0]  alu_v2,
  output logic [DATA_W-1:0]  alu_imm,
  output logic [DATA_W-1:0]  alu_pc,
  output logic [ROB_BIT-1:0] alu_rob_id
);
  cdb_t cdb0, cdb1;
  assign cdb0 = '{valid: cdb0_valid, rob_id: cdb0_rob_id, value: cdb0_value};
  assign cdb1 = '{valid: cdb1_valid, rob_id: cdb1_rob_id, value: cdb1_value};

  logic [RS_SIZE-1:0] busy, prepared;
  rs_entry_t          ent [RS_SIZE];
  operand_t           wj  [RS_SIZE];
  operand_t           wk  [RS_SIZE];

  for (genvar i = 0; i < RS_SIZE; i++) begin : g_ent
    assign prepared[i] = busy[i] & ~ent[i].qj_valid & ~ent[i].qk_valid;
    assign wj[i] = snoop(ent[i].qj_valid, ent[i].qj, ent[i].vj, cdb0, cdb1);
    assign wk[i] = snoop(ent[i].qk_valid, ent[i].qk, ent[i].vk, cdb0, cdb1);
  end

  logic              free_found, disp_found;
  logic [RS_BIT-1:0] free_idx, disp_idx;

  rs_picker #(.N(RS_SIZE), .W(RS_BIT)) u_issue_pick (
    .req(~busy), .found(free_found), .idx(free_idx)
  );
  rs_picker #(.N(RS_SIZE), .W(RS_BIT)) u_disp_pick (
    .req(prepared), .found(disp_found), .idx(disp_idx)
  );

  // full_out ignores a same-cycle dispatch, so the freed slot is only
  // offered to issue on the next cycle.
  assign full_out = ~free_found;

  // Incoming operands can be satisfied by a CDB broadcast in the same cycle.
  operand_t  ij, ik;
  rs_entry_t new_ent;
  assign ij = snoop(issue_qj_valid, issue_qj, issue_vj, cdb0, cdb1);
  assign ik = snoop(issue_qk_valid, issue_qk, issue_vk, cdb0, cdb1);
  assign new_ent = '{op: issue_op, vj: ij.val, vk: ik.val,
                     qj_valid: ij.pend, qj: issue_qj,
                     qk_valid: ik.pend, qk: issue_qk,
                     rob_id: issue_rob_id, imm: issue_imm, pc: issue_pc};

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy       <= '0;
      alu_valid  <= 1'b0;
      alu_op     <= '0;
      alu_v1     <= '0;
      alu_v2     <= '0;
      alu_imm    <= '0;
      alu_pc     <= '0;
      alu_rob_id <= '0;
    end else if (clear_in) begin
      busy      <= '0;
      alu_valid <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          ent[i].qj_valid <= wj[i].pend;
          ent[i].vj       <= wj[i].val;
          ent[i].qk_valid <= wk[i].pend;
          ent[i].vk       <= wk[i].val;
        end
      end
      alu_valid <= disp_found;
      if (disp_found) begin
        alu_op         <= ent[disp_idx].op;
        alu_v1         <= ent[disp_idx].vj;
        alu_v2         <= ent[disp_idx].vk;
        alu_imm        <= ent[disp_idx].imm;
        alu_pc         <= ent[disp_idx].pc;
        alu_rob_id     <= ent[disp_idx].rob_id;
        busy[disp_idx] <= 1'b0;
      end
      // The free slot is never busy, so it cannot collide with the
      // dispatch slot or with any wakeup write above.
      if (issue_valid && free_found) begin
        busy[free_idx] <= 1'b1;
        ent[free_idx]  <= new_ent;
      end
    end
  end
endmodule

// File: tb/tb_rs_station.sv
// Randomised and directed bench for rs_station. A behavioural model
// steps once per clock edge and pushes every expected dispatch, stamped
// with its edge number, into a scoreboard queue. A separate monitor
// compares the DUT outputs against that queue.
module tb_rs_station;
  import rs_station_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear_in, issue_valid;
  logic [OP_W-1:0] issue_op;
  logic [DATA_W-1:0] issue_vj, issue_vk, issue_imm, issue_pc;
  logic issue_qj_valid, issue_qk_valid;
  logic [ROB_BIT-1:0] issue_qj, issue_qk, issue_rob_id;
  logic full_out;
  logic cdb0_valid, cdb1_valid;
  logic [ROB_BIT-1:0] cdb0_rob_id, cdb1_rob_id;
  logic [DATA_W-1:0] cdb0_value, cdb1_value;
  logic alu_valid;
  logic [OP_W-1:0] alu_op;
  logic [DATA_W-1:0] alu_v1, alu_v2, alu_imm, alu_pc;
  logic [ROB_BIT-1:0] alu_rob_id;

  rs_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_valid(issue_qj_valid), .issue_qk_valid(issue_qk_valid),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_rob_id(issue_rob_id),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .full_out(full_out),
    .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_value(cdb1_value),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_id(alu_rob_id)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  typedef struct {
    bit busy; logic [5:0] op; logic [31:0] vj, vk; bit qjv; logic [3:0] qj;
    bit qkv; logic [3:0] qk; logic [3:0] rob; logic [31:0] imm, pc;
  } m_ent_t;
  typedef struct {
    int stamp; logic [5:0] op; logic [31:0] v1, v2, imm, pc; logic [3:0] rob;
  } exp_t;

  m_ent_t m [16];
  exp_t   sb [$];
  exp_t   exp_rec;
  bit     exp_valid, m_full, m_active, mon_en;
  int     edge_cnt, errs, checks;

  function automatic logic [32:0] tb_snoop(input bit pend, input logic [3:0] tag, input logic [31:0] v);
    if (pend && cdb0_valid && cdb0_rob_id == tag) return {1'b0, cdb0_value};
    if (pend && cdb1_valid && cdb1_rob_id == tag) return {1'b0, cdb1_value};
    return {pend, v};
  endfunction

  task automatic model_edge();
    int fi, di;
    edge_cnt++;
    m_active = 0;
    if (!rst_in) begin
      foreach (m[i]) m[i].busy = 0;
      exp_valid = 0;
      exp_rec = '{0, 0, 0, 0, 0, 0, 0};
    end else if (clear_in) begin
      foreach (m[i]) m[i].busy = 0;
      exp_valid = 0;
    end else if (rdy_in) begin
      m_active = 1;
      fi = -1; di = -1;
      for (int i = 0; i < 16; i++) begin
        if (!m[i].busy && fi < 0) fi = i;
        if (m[i].busy && !m[i].qjv && !m[i].qkv && di < 0) di = i;
      end
      exp_valid = (di >= 0);
      if (di >= 0) begin
        exp_rec = '{edge_cnt, m[di].op, m[di].vj, m[di].vk, m[di].imm, m[di].pc, m[di].rob};
        sb.push_back(exp_rec);
        m[di].busy = 0;
      end
      for (int i = 0; i < 16; i++) begin
        if (m[i].busy) begin
          {m[i].qjv, m[i].vj} = tb_snoop(m[i].qjv, m[i].qj, m[i].vj);
          {m[i].qkv, m[i].vk} = tb_snoop(m[i].qkv, m[i].qk, m[i].vk);
        end
      end
      if (issue_valid && fi >= 0) begin
        m[fi].busy = 1; m[fi].op = issue_op; m[fi].qj = issue_qj; m[fi].qk = issue_qk;
        m[fi].rob = issue_rob_id; m[fi].imm = issue_imm; m[fi].pc = issue_pc;
        {m[fi].qjv, m[fi].vj} = tb_snoop(issue_qj_valid, issue_qj, issue_vj);
        {m[fi].qkv, m[fi].vk} = tb_snoop(issue_qk_valid, issue_qk, issue_vk);
      end
    end
    m_full = 1;
    foreach (m[i]) if (!m[i].busy) m_full = 0;
  endtask

  task automatic chk(input string name, input logic [137:0] act, input logic [137:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, edge_cnt);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t r;
    forever begin
      @(negedge clk_in);
      if (mon_en) begin
        chk("full_out", 138'(full_out), 138'(m_full));
        chk("alu_valid", 138'(alu_valid), 138'(exp_valid));
        if (alu_valid) begin
          if (m_active) begin
            if (sb.size() == 0) begin
              checks++; errs++;
              $display("FAIL sb_empty: dispatch seen with no expected entry (edge %0d)", edge_cnt);
            end else begin
              r = sb.pop_front();
              chk("alu_edge", 138'(edge_cnt), 138'(r.stamp));
              chk("alu_data", {alu_op, alu_v1, alu_v2, alu_imm, alu_pc, alu_rob_id},
                  {r.op, r.v1, r.v2, r.imm, r.pc, r.rob});
            end
          end else begin
            chk("alu_hold", {alu_op, alu_v1, alu_v2, alu_imm, alu_pc, alu_rob_id},
                {exp_rec.op, exp_rec.v1, exp_rec.v2, exp_rec.imm, exp_rec.pc, exp_rec.rob});
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
  endtask

  task automatic idle();
    issue_valid = 0; issue_op = '0; issue_vj = '0; issue_vk = '0;
    issue_qj_valid = 0; issue_qk_valid = 0; issue_qj = '0; issue_qk = '0;
    issue_rob_id = '0; issue_imm = '0; issue_pc = '0;
    cdb0_valid = 0; cdb0_rob_id = '0; cdb0_value = '0;
    cdb1_valid = 0; cdb1_rob_id = '0; cdb1_value = '0;
    clear_in = 0; rdy_in = 1;
  endtask

  task automatic iss(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                     input bit qjv, input logic [3:0] qj, input bit qkv, input logic [3:0] qk,
                     input logic [3:0] rob);
    issue_valid = 1; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj_valid = qjv; issue_qj = qj; issue_qk_valid = qkv; issue_qk = qk;
    issue_rob_id = rob; issue_imm = $urandom; issue_pc = $urandom;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    errs = 0; checks = 0; edge_cnt = 0; mon_en = 0;
    idle();
    rst_in = 0;
    @(negedge clk_in);
    tick(); tick();
    chk("rst_alu_valid", 138'(alu_valid), 138'(0));
    chk("rst_alu_data", {alu_op, alu_v1, alu_v2, alu_imm, alu_pc, alu_rob_id}, 138'(0));
    chk("rst_full", 138'(full_out), 138'(0));
    rst_in = 1;
    mon_en = 1;

    // Ready operands: dispatch exactly one edge after issue.
    iss(OP_ADD, 5, 7, 0, 0, 0, 0, 3); tick(); idle();
    chk("s1_early", 138'(alu_valid), 138'(0));
    tick();
    chk("s1_v1", 138'(alu_v1), 138'(5));
    chk("s1_v2", 138'(alu_v2), 138'(7));
    chk("s1_rob", 138'(alu_rob_id), 138'(3));
    tick(); tick();

    // Wakeup from cdb1 two cycles after issue.
    iss(OP_SUB, 0, 11, 1, 2, 0, 0, 6); tick(); idle();
    tick(); tick();
    cdb1_valid = 1; cdb1_rob_id = 2; cdb1_value = 32'h10; tick(); idle();
    tick();
    chk("s2_v1", 138'(alu_v1), 138'(32'h10));
    tick(); tick();

    // Same-cycle bypass from cdb0 on the vk operand.
    iss(OP_AND, 1, 0, 0, 0, 1, 4, 8);
    cdb0_valid = 1; cdb0_rob_id = 4; cdb0_value = 9; tick(); idle();
    tick();
    chk("s3_v2", 138'(alu_v2), 138'(9));
    tick(); tick();

    // Fill all 16 entries, attempt a 17th issue, then release them all.
    for (int i = 0; i < 16; i++) begin
      iss(OP_OR, $urandom, $urandom, 1, 1, 0, 0, 4'(i)); tick();
    end
    chk("s4_full", 138'(full_out), 138'(1));
    iss(OP_XOR, 1, 2, 0, 0, 0, 0, 4'd15); tick(); idle();
    cdb0_valid = 1; cdb0_rob_id = 1; cdb0_value = 32'hABCD; tick(); idle();
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("s4_order", 138'(alu_rob_id), 138'(i));
    end
    tick(); tick();

    // Entries 3 and 7 become ready together; freeze between the dispatches.
    for (int i = 0; i < 8; i++) begin
      iss(OP_SLT, $urandom, $urandom, 1, (i == 3 || i == 7) ? 4'd6 : 4'd5, 0, 0, 4'(i)); tick();
    end
    idle();
    cdb1_valid = 1; cdb1_rob_id = 6; cdb1_value = 32'h77; tick(); idle();
    tick();
    chk("s5_first", 138'(alu_rob_id), 138'(3));
    rdy_in = 0; tick(); tick();
    chk("s5_frozen", 138'(alu_rob_id), 138'(3));
    rdy_in = 1; tick();
    chk("s5_second", 138'(alu_rob_id), 138'(7));
    tick();

    // Flush with a simultaneous issue: the issue is dropped.
    iss(OP_ADD, 1, 1, 0, 0, 0, 0, 4'd9); clear_in = 1; tick(); idle();
    chk("s6_full", 138'(full_out), 138'(0));
    chk("s6_valid", 138'(alu_valid), 138'(0));
    tick();
    chk("s6_dropped", 138'(alu_valid), 138'(0));
    tick();

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      idle();
      if ($urandom_range(0, 9) < 6)
        iss(6'($urandom_range(0, 9)), $urandom, $urandom, $urandom_range(0, 9) < 4, 4'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 4, 4'($urandom_range(0, 7)), 4'($urandom));
      cdb0_valid = $urandom_range(0, 1) == 1; cdb0_rob_id = 4'($urandom_range(0, 7)); cdb0_value = $urandom;
      cdb1_valid = $urandom_range(0, 1) == 1; cdb1_rob_id = 4'($urandom_range(0, 7)); cdb1_value = $urandom;
      rdy_in = $urandom_range(0, 9) != 0;
      clear_in = $urandom_range(0, 63) == 0;
      tick();
    end
    idle();
    for (int c = 0; c < 20; c++) tick();
    chk("sb_drained", 138'(sb.size()), 138'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rs_station.md
Name: rs_station

Overview:
- Reservation-station storage for the ALU path: holds RS_SIZE entries issued by the decoder/ROB stage, snoops two CDB result buses to resolve operand tags, and dispatches one operand-complete entry per cycle to the ALU.
- Produces per-entry busy/prepared vectors internally, then selects the lowest-index free slot for issue and the lowest-index prepared slot for dispatch.

Parameters:
- RS_SIZE, 16, number of entries (power of 2)
- RS_BIT, 4, log2(RS_SIZE)
- ROB_BIT, 4, ROB tag width
- OP_W, 6, internal opcode width
- DATA_W, 32, operand/result width

Ports:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  synchronous reset, active-low
- rdy_in  in  1  global ready; low = freeze all state
- clear_in  in  1  misprediction flush
- issue_valid  in  1  new instruction this cycle
- issue_op  in  OP_W  opcode
- issue_vj / issue_vk  in  DATA_W  operand values (valid when no dependency)
- issue_qj_valid / issue_qk_valid  in  1  operand still pending
- issue_qj / issue_qk  in  ROB_BIT  pending producer tag
- issue_rob_id  in  ROB_BIT  destination ROB tag
- issue_imm  in  DATA_W  immediate
- issue_pc  in  DATA_W  instruction PC
- full_out  out  1  no free entry (combinational from busy)
- cdb0_valid, cdb1_valid  in  1  result broadcast valid
- cdb0_rob_id, cdb1_rob_id  in  ROB_BIT  broadcast tag
- cdb0_value, cdb1_value  in  DATA_W  broadcast value
- alu_valid  out  1  dispatched op valid (registered)
- alu_op  out  OP_W; alu_v1, alu_v2, alu_imm, alu_pc  out  DATA_W; alu_rob_id  out  ROB_BIT

Behaviour:
- Entry fields: busy, op, vj, vk, qj_valid, qj, qk_valid, qk, rob_id, imm, pc. prepared = busy & !qj_valid & !qk_valid.
- Reset (rst_in=0 at edge): all busy=0; alu_valid=0; alu_* data=0. Reset overrides everything.
- Priority per edge: reset > clear_in > rdy_in low (hold) > normal.
- clear_in=1 (rdy_in ignored): all busy=0, alu_valid=0 next cycle; any issue/dispatch that cycle is dropped.
- rdy_in=0: no register changes, alu_* outputs included; consumer gates on rdy_in.
- Issue: if issue_valid & !full_out, write lowest-index non-busy entry (as of current state); busy=1. issue_valid while full_out=1 is ignored (issuer protocol error, no state change).
- Issue bypass: incoming operand whose tag matches a same-cycle valid CDB is written with that CDB value and qX_valid=0.
- Wakeup: each busy entry whose qj/qk equals a valid CDB tag captures the value and clears qX_valid at the edge. If both CDBs carry the same tag, cdb0 wins.
- Dispatch: if any entry is prepared (current state), lowest index is chosen; alu_* registered from it, alu_valid=1 next cycle, entry busy=0 at the same edge. No prepared entry -> alu_valid=0.
- Latency: issue with ready operands at edge t -> dispatch at edge t+1 (alu_valid high in cycle after t+1). CDB wakeup at edge t -> earliest dispatch edge t+1.
- Slot freed by dispatch at edge t becomes issuable from edge t+1; full_out reflects pre-dispatch state (conservative).
- Issue and dispatch to different slots in the same cycle are both allowed.

Decomposition:
- Shared package/include: RS_SIZE, RS_BIT, ROB_BIT, OP_W, DATA_W, opcode encodings.
- Sub-module rs_picker: combinational lowest-index priority encoder over an RS_SIZE bit vector, giving found and index. Instantiate it twice: prepared vector for dispatch and ~busy vector for issue.

Test Plan:
- Reset, then issue op=ADD vj=5 vk=7, no deps, rob_id=3 -> exactly one cycle later alu_valid=1, alu_v1=5, alu_v2=7, alu_rob_id=3; entry freed.
- Issue qj_valid=1 qj=2; two cycles later cdb1 tag=2 value=0x10 -> dispatch next edge with alu_v1=0x10; no dispatch before the CDB.
- Issue qk=4 in the same cycle as cdb0 tag=4 value=9 -> bypass; alu_v2=9 one cycle later.
- Fill 16 entries all waiting on tag 1 -> full_out=1; a 17th issue is ignored; cdb0 tag=1 -> entries dispatch in index order 0..15 on consecutive cycles.
- Entries at index 3 and 7 prepared together -> 3 dispatches first, 7 next cycle; hold rdy_in=0 for 2 cycles in between -> outputs frozen, then resume.
- 5 busy entries, assert clear_in with issue_valid=1 -> next cycle all busy=0, full_out=0, alu_valid=0; issued op is dropped.
